// File: rtl/accel_spi_pkg.sv
// Shared definitions for the accelerometer SPI responder.
// Contents: register map addresses, reset values, FSM state codes and
// address-classification helpers used by the responder top level.
package accel_spi_pkg;

  // Register map (6-bit address space, ADXL345 layout)
  localparam logic [5:0] DEVID_A     = 6'h00;
  localparam logic [5:0] BW_RATE     = 6'h2C;
  localparam logic [5:0] INT_ENABLE  = 6'h2E;
  localparam logic [5:0] INT_SOURCE  = 6'h30;
  localparam logic [5:0] DATA_FORMAT = 6'h31;
  localparam logic [5:0] DATAX0      = 6'h32;
  localparam logic [5:0] DATAX1      = 6'h33;
  localparam logic [5:0] DATAY0      = 6'h34;
  localparam logic [5:0] DATAY1      = 6'h35;
  localparam logic [5:0] DATAZ0      = 6'h36;
  localparam logic [5:0] DATAZ1      = 6'h37;

  // Reset values
  localparam logic [7:0] DEVID_RST   = 8'hE5;
  localparam logic [7:0] BW_RATE_RST = 8'h0A;

  // Bit positions inside control registers
  localparam int DATA_READY_BIT = 7;  // INT_SOURCE / INT_ENABLE
  localparam int INT_INVERT_BIT = 5;  // DATA_FORMAT

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  function automatic logic is_axis(input logic [5:0] a);
    return (a >= DATAX0) && (a <= DATAZ1);
  endfunction

  function automatic logic is_read_only(input logic [5:0] a);
    return (a == DEVID_A) || (a == INT_SOURCE) || is_axis(a);
  endfunction

  function automatic logic [7:0] reset_value(input logic [5:0] a,
                                             input logic [7:0] devid);
    if (a == DEVID_A) return devid;
    if (a == BW_RATE) return BW_RATE_RST;
    return 8'h00;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer with edge detection for one asynchronous input.
// Ports:
//   clk, rst_n  - system clock, synchronous active-low reset
//   din         - asynchronous input
//   level       - synchronized level
//   rise, fall  - single-cycle pulses on synchronized rising/falling edges
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/accel_spi_responder.sv
// 3-wire SPI mode-3 responder emulating an ADXL345-style accelerometer.
// Ports:
//   clk_clk, reset_reset_n       - system clock, synchronous active-low reset
//   spi_sclk, spi_cs_n           - serial clock (idles high), chip select
//   spi_sdat_in                  - receive side of the shared data line
//   spi_sdat_out, spi_sdat_oe    - drive value and drive enable for the data line
//   spi_int                      - DATA_READY interrupt pin
//   sample_x/y/z, sample_valid   - host-side axis sample port
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_in,
  output logic        spi_sdat_out,
  output logic        spi_sdat_oe,
  output logic        spi_int,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic sdat_level, sdat_rise, sdat_fall;

  spi_edge_sync #(.STAGES(STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));

  spi_edge_sync #(.STAGES(STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall));

  spi_edge_sync #(.STAGES(STAGES), .RESET_VAL(1'b0)) u_sync_sdat (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sdat_in),
    .level(sdat_level), .rise(sdat_rise), .fall(sdat_fall));

  // Only the data-line level and the sclk/cs edges drive the FSM.
  logic unused_sync;
  assign unused_sync = ^{sclk_level, cs_level, sdat_rise, sdat_fall};

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  tx_reg;
  logic [5:0]  addr;
  logic        mb;
  logic [7:0]  regs [64];
  logic        pend_valid;
  logic [15:0] pend_x, pend_y, pend_z;

  logic [7:0]  rx_byte;
  logic [5:0]  next_addr;
  logic        byte_done;
  logic        in_txn, leaving;
  logic        apply_now, apply_pend;
  logic [15:0] src_x, src_y, src_z;

  assign rx_byte    = {shreg[6:0], sdat_level};
  assign next_addr  = mb ? addr + 6'd1 : addr;   // 6-bit wrap is implicit
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
  assign in_txn     = (state != ST_IDLE);
  assign leaving    = in_txn && cs_rise;
  // Axis registers only change while no burst is in progress: directly in
  // IDLE, otherwise from the pending buffer on the cycle the burst ends.
  assign apply_now  = sample_valid && (!in_txn || leaving);
  assign apply_pend = leaving && pend_valid && !sample_valid;
  assign src_x      = apply_now ? sample_x : pend_x;
  assign src_y      = apply_now ? sample_y : pend_y;
  assign src_z      = apply_now ? sample_z : pend_z;

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      tx_reg       <= 8'h00;
      addr         <= 6'd0;
      mb           <= 1'b0;
      spi_sdat_out <= 1'b0;
      spi_sdat_oe  <= 1'b0;
      spi_int      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_x       <= 16'h0000;
      pend_y       <= 16'h0000;
      pend_z       <= 16'h0000;
      // NOTE: the register file is architecturally visible with defined
      // power-on values, so it is reset like any control register.
      for (int i = 0; i < 64; i++) regs[i] <= reset_value(6'(i), DEVID);
    end else begin
      spi_int <= (regs[INT_SOURCE][DATA_READY_BIT] & regs[INT_ENABLE][DATA_READY_BIT])
                 ^ regs[DATA_FORMAT][INT_INVERT_BIT];

      if (leaving) begin
        // Any partial byte is simply dropped.
        state        <= ST_IDLE;
        bit_cnt      <= 3'd0;
        spi_sdat_oe  <= 1'b0;
        spi_sdat_out <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= 3'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                mb   <= rx_byte[6];
                addr <= rx_byte[5:0];
                if (rx_byte[7]) begin
                  state  <= ST_RD;
                  tx_reg <= regs[rx_byte[5:0]];
                end else begin
                  state  <= ST_WR;
                end
              end
            end
          end
          ST_WR: begin
            if (sclk_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (!is_read_only(addr)) regs[addr] <= rx_byte;
                addr <= next_addr;
              end
            end
          end
          default: begin  // ST_RD
            if (sclk_fall) begin
              spi_sdat_out <= tx_reg[7];
              spi_sdat_oe  <= 1'b1;
              tx_reg       <= {tx_reg[6:0], 1'b0};
            end
            // The initiator samples on rising edges, so the byte is complete
            // once the 8th rising edge has been seen.
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (is_axis(addr)) regs[INT_SOURCE][DATA_READY_BIT] <= 1'b0;
                addr   <= next_addr;
                tx_reg <= regs[next_addr];
              end
            end
          end
        endcase
      end

      // Placed after the FSM so a DATA_READY set wins over a same-cycle clear.
      if (apply_now || apply_pend) begin
        regs[DATAX0] <= src_x[7:0];
        regs[DATAX1] <= src_x[15:8];
        regs[DATAY0] <= src_y[7:0];
        regs[DATAY1] <= src_y[15:8];
        regs[DATAZ0] <= src_z[7:0];
        regs[DATAZ1] <= src_z[15:8];
        regs[INT_SOURCE][DATA_READY_BIT] <= 1'b1;
      end

      if (sample_valid && in_txn && !leaving) begin
        pend_valid <= 1'b1;
        pend_x     <= sample_x;
        pend_y     <= sample_y;
        pend_z     <= sample_z;
      end else if (leaving) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Self-checking bench for accel_spi_responder: a table of single-byte
// register transactions, hand-written corner-case sequences, and random
// transactions checked against a transaction-level register model.
module tb_accel_spi_responder;

  localparam int H = 5;  // clk cycles per sclk half period (sclk = clk/10)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs_n, sdat_in;
  logic        sdat_out, sdat_oe, int_pin;
  logic [15:0] sx, sy, sz;
  logic        sv;

  always #5 clk = ~clk;

  accel_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_sdat_in(sdat_in),
    .spi_sdat_out(sdat_out), .spi_sdat_oe(sdat_oe), .spi_int(int_pin),
    .sample_x(sx), .sample_y(sy), .sample_z(sz), .sample_valid(sv));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0]  m_regs [64];
  logic        m_dr;
  logic        m_pend;
  logic [15:0] m_px, m_py, m_pz;
  logic [7:0]  tx_buf  [16];
  logic [7:0]  rx_buf  [16];
  logic [7:0]  exp_buf [16];

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_regs[0]     = 8'hE5;
    m_regs[8'h2C] = 8'h0A;
    m_dr   = 1'b0;
    m_pend = 1'b0;
  endfunction

  function automatic logic m_ro(input int a);
    return (a == 8'h00) || (a == 8'h30) || (a >= 8'h32 && a <= 8'h37);
  endfunction

  function automatic void m_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_regs[8'h32] = x[7:0]; m_regs[8'h33] = x[15:8];
    m_regs[8'h34] = y[7:0]; m_regs[8'h35] = y[15:8];
    m_regs[8'h36] = z[7:0]; m_regs[8'h37] = z[15:8];
    m_dr = 1'b1;
  endfunction

  function automatic logic [7:0] m_peek(input int a);
    return (a == 8'h30) ? {m_dr, 7'b0} : m_regs[a];
  endfunction

  // Applies one complete transaction; read data lands in exp_buf.
  function automatic void m_txn(input logic [7:0] cmd, input int nbytes);
    int a;
    a = int'(cmd[5:0]);
    for (int k = 0; k < nbytes; k++) begin
      if (cmd[7]) begin
        exp_buf[k] = m_peek(a);
        if (a >= 8'h32 && a <= 8'h37) m_dr = 1'b0;
      end else if (!m_ro(a)) begin
        m_regs[a] = tx_buf[k];
      end
      if (cmd[6]) a = (a + 1) % 64;
    end
    if (m_pend) begin
      m_load(m_px, m_py, m_pz);
      m_pend = 1'b0;
    end
  endfunction

  function automatic logic m_int();
    return (m_dr & m_regs[8'h2E][7]) ^ m_regs[8'h31][5];
  endfunction

  // ---------------- initiator ----------------
  int          abort_bits = -1;
  int          mid_bit    = -1;
  logic [15:0] mid_x, mid_y, mid_z;
  logic        oe_cmd, oe_data, oe_after;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sx = x; sy = y; sz = z; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
  endtask

  // One sclk period: drive on the falling edge, sample just before rising.
  task automatic clock_bit(input logic b, output logic s, output logic oe);
    sclk = 1'b0; sdat_in = b;
    wait_clk(H);
    s = sdat_out; oe = sdat_oe;
    sclk = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int nbytes);
    int nb, idx, bi;
    logic [7:0] b;
    logic s, oe;
    nb = 8 * (nbytes + 1);
    oe_cmd = 1'b0; oe_data = 1'b1;
    cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_bits) break;
      idx = i / 8;
      bi  = 7 - (i % 8);
      if (i == mid_bit) pulse_sample(mid_x, mid_y, mid_z);
      b = (idx == 0) ? cmd : (cmd[7] ? 8'h00 : tx_buf[idx-1]);
      clock_bit(b[bi], s, oe);
      if (idx == 0) oe_cmd = oe_cmd | oe;
      else begin
        rx_buf[idx-1][bi] = s;
        oe_data = oe_data & oe;
      end
    end
    cs_n = 1'b1;
    wait_clk(4);
    oe_after = sdat_oe;
    wait_clk(2 * H);
  endtask

  task automatic wr1(input logic [5:0] a, input logic [7:0] d);
    tx_buf[0] = d;
    spi_txn({2'b00, a}, 1);
    m_txn({2'b00, a}, 1);
  endtask

  task automatic rd(input logic [7:0] cmd, input int n);
    spi_txn(cmd, n);
    m_txn(cmd, n);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [7:0] cmd;
    logic [7:0] exp6 [6];
    logic s, oe;
    int n;

    vecs = '{
      '{8'h80, 8'h00, 8'hE5},  // DEVID
      '{8'h31, 8'h0B, 8'h00},  // write DATA_FORMAT
      '{8'hB1, 8'h00, 8'h0B},
      '{8'h00, 8'h12, 8'h00},  // write to DEVID is dropped
      '{8'h80, 8'h00, 8'hE5},
      '{8'hAC, 8'h00, 8'h0A},  // BW_RATE reset value
      '{8'hB0, 8'h00, 8'h00},  // INT_SOURCE reset value
      '{8'h05, 8'h5A, 8'h00},
      '{8'h85, 8'h00, 8'h5A},
      '{8'h30, 8'hFF, 8'h00},  // INT_SOURCE is read-only
      '{8'hB0, 8'h00, 8'h00},
      '{8'h31, 8'h00, 8'h00},
      '{8'hB1, 8'h00, 8'h00}
    };
    exp6 = '{8'h23, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h01};

    rst_n = 1'b0; sclk = 1'b1; cs_n = 1'b1; sdat_in = 1'b0;
    sv = 1'b0; sx = '0; sy = '0; sz = '0;
    m_reset();
    wait_clk(4);
    check("reset_oe",  sdat_oe,  1'b0);
    check("reset_out", sdat_out, 1'b0);
    check("reset_int", int_pin,  1'b0);
    rst_n = 1'b1;
    wait_clk(4);

    // ---- table of single-byte transactions ----
    for (int v = 0; v < 13; v++) begin
      tx_buf[0] = vecs[v].data;
      rd(vecs[v].cmd, 1);
      check($sformatf("vec%0d_oe_cmd", v), oe_cmd, 1'b0);
      if (vecs[v].cmd[7]) begin
        check($sformatf("vec%0d_rd", v), rx_buf[0], vecs[v].exp);
        check($sformatf("vec%0d_oe_data", v), oe_data, 1'b1);
        check($sformatf("vec%0d_oe_drop", v), oe_after, 1'b0);
      end
    end

    // ---- sample in IDLE, 6-byte multibyte read ----
    pulse_sample(16'h0123, 16'hFFFE, 16'h0100);
    m_load(16'h0123, 16'hFFFE, 16'h0100);
    wait_clk(2);
    rd(8'hF2, 6);
    for (int k = 0; k < 6; k++) check($sformatf("burst_b%0d", k), rx_buf[k], exp6[k]);
    rd(8'hB0, 1);
    check("dr_cleared", rx_buf[0], 8'h00);

    // ---- interrupt pin ----
    wr1(6'h2E, 8'h80);
    pulse_sample(16'h4455, 16'h0000, 16'h0000);
    m_load(16'h4455, 16'h0000, 16'h0000);
    wait_clk(3);
    check("int_set", int_pin, 1'b1);
    wr1(6'h31, 8'h20);
    check("int_inverted", int_pin, 1'b0);
    rd(8'hB2, 1);
    check("int_inv_dr_clr", int_pin, 1'b1);
    wr1(6'h31, 8'h00);
    check("int_plain_clr", int_pin, 1'b0);

    // ---- sample arriving mid-burst is deferred ----
    mid_bit = 12; mid_x = 16'h1111; mid_y = 16'h2222; mid_z = 16'h3333;
    m_pend = 1'b1; m_px = mid_x; m_py = mid_y; m_pz = mid_z;
    rd(8'hF2, 2);
    mid_bit = -1;
    check("mid_old_lo", rx_buf[0], 8'h55);
    check("mid_old_hi", rx_buf[1], 8'h44);
    check("mid_int_after", int_pin, 1'b1);
    rd(8'hB2, 1);
    check("mid_new_lo", rx_buf[0], 8'h11);

    // ---- partial write byte is discarded ----
    abort_bits = 13;
    tx_buf[0] = 8'h00;
    spi_txn(8'h2E, 1);
    abort_bits = -1;
    rd(8'hAE, 1);
    check("abort_wr_kept", rx_buf[0], 8'h80);

    // ---- random transactions against the model ----
    for (int t = 0; t < 40; t++) begin
      cmd = 8'($urandom);
      n   = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
        pulse_sample(sx, sy, sz);
        m_load(sx, sy, sz);
        wait_clk(2);
      end
      if ($urandom_range(0, 3) == 0) begin
        mid_bit = $urandom_range(8, 8 * (n + 1) - 1);
        mid_x = 16'($urandom); mid_y = 16'($urandom); mid_z = 16'($urandom);
        m_pend = 1'b1; m_px = mid_x; m_py = mid_y; m_pz = mid_z;
      end
      rd(cmd, n);
      mid_bit = -1;
      if (cmd[7])
        for (int k = 0; k < n; k++)
          check($sformatf("rand%0d_cmd%02h_b%0d", t, cmd, k), rx_buf[k], exp_buf[k]);
      check($sformatf("rand%0d_int", t), int_pin, m_int());
    end

    // ---- reset asserted mid-read ----
    wr1(6'h2C, 8'h55);
    cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 11; i++) clock_bit(1'b0 ^ (i == 0), s, oe);
    check("pre_reset_oe", sdat_oe, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_oe", sdat_oe, 1'b0);
    cs_n = 1'b1; sclk = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    m_reset();
    wait_clk(5);
    rd(8'hAC, 1);
    check("post_reset_bw", rx_buf[0], 8'h0A);
    rd(8'hAE, 1);
    check("post_reset_inten", rx_buf[0], 8'h00);
    rd(8'h80, 1);
    check("post_reset_devid", rx_buf[0], 8'hE5);
    check("post_reset_int", int_pin, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
Name: accel_spi_responder

Overview:
- Synthesizable 3-wire SPI responder (mode 3: CPOL=1, CPHA=1) modelling the G-sensor end of the accelerometer SPI link.
- Presents an ADXL345-style 64x8 register file and an interrupt pin to the on-chip SPI initiator.
- Lets the Nios accelerometer software path run in simulation and on boards without the sensor.
- Axis data is supplied by a host-side sample port.

Parameters:
- DEVID, 8'hE5, value returned at address 0x00
- SYNC_STAGES, 2, flip-flop stages on the sclk, cs_n and sdat inputs (minimum 2)

Ports:
- clk_clk  input  1  system clock; sclk must not exceed clk_clk/8
- reset_reset_n  input  1  synchronous reset, active low
- spi_sclk  input  1  serial clock from initiator, idles high
- spi_cs_n  input  1  chip select, active low
- spi_sdat_in  input  1  bidirectional data line, receive side
- spi_sdat_out  output  1  bidirectional data line, drive value
- spi_sdat_oe  output  1  drive enable for spi_sdat_out
- spi_int  output  1  DATA_READY interrupt pin
- sample_x, sample_y, sample_z  input  16 each  signed axis samples
- sample_valid  input  1  one-cycle strobe; sample_x/y/z are valid in that cycle

Behaviour:
- Reset (sampled on clk_clk edge while reset_reset_n=0): FSM=IDLE; spi_sdat_oe=0, spi_sdat_out=0, spi_int=0.
- Reset register values: all 0x00 except 0x00=DEVID, 0x2C=0x0A. Pending-sample flag cleared.
- Reset asserted mid-transaction aborts the transaction immediately.
- Inputs pass through SYNC_STAGES synchronizers, then an edge detector. The detected edge acts 1 cycle later, so total input latency is SYNC_STAGES+1 clk_clk cycles.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE->CMD on cs_n falling edge; bit_cnt=0.
  - CMD: shift spi_sdat_in MSB-first on each sclk rising edge. After the 8th bit, decode rw=bit7, mb=bit6, addr=bits5:0. rw=1 -> RD, rw=0 -> WR.
  - WR: shift 8 bits on rising edges, then commit the byte to reg[addr]. Writes to read-only addresses are silently dropped.
  - RD: on entry, load the shift-out register with reg[addr] (live value). On each sclk falling edge, set spi_sdat_out=next MSB and spi_sdat_oe=1. oe stays 1 until CS deasserts.
  - After each full data byte: if mb=1, addr=addr+1 with 6-bit wrap 0x3F->0x00; if mb=0, addr is unchanged and the same register repeats. RD reloads the shift-out register for the next byte.
  - cs_n rising edge in any state -> IDLE. A partial byte is discarded (no write, no increment). spi_sdat_oe=0 on the cycle the edge is detected.
  - sclk edges while cs_n is high are ignored.
- Read-only addresses: 0x00, 0x30, 0x32-0x37. All others are read/write storage.
- Axis registers: 0x32/0x33 = X low/high, 0x34/0x35 = Y, 0x36/0x37 = Z, little-endian.
- Sample handling:
  - sample_valid with FSM=IDLE: load the axis registers that cycle and set DATA_READY (0x30 bit7).
  - sample_valid during a transaction: latch into a pending buffer; the newest sample wins. Apply the pending buffer and set DATA_READY on the cycle the FSM returns to IDLE.
  - Axis bytes therefore never change mid-burst.
- DATA_READY is cleared when an RD byte from 0x32-0x37 completes. If set and clear occur in the same cycle, set wins.
- spi_int = DATA_READY & reg[0x2E][7], XORed with reg[0x31][5] (INT_INVERT). It is registered, so it updates 1 cycle after either term changes.
- Response deadline: spi_sdat_out changes within SYNC_STAGES+2 clk_clk cycles of the sclk falling edge. This is inside the half-period guaranteed by the clk_clk/8 limit.

Decomposition:
- accel_spi_pkg:
  - register address localparams (DEVID_A=0x00, BW_RATE=0x2C, INT_ENABLE=0x2E, INT_SOURCE=0x30, DATA_FORMAT=0x31, DATAX0..DATAZ1=0x32..0x37)
  - reset-value constants
  - FSM state enum
  - read-only address function
- Sub-module spi_edge_sync: a SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated once each for sclk, cs_n and sdat.

Test Plan:
- Read 0x00 (cmd 0x80, 8 more clocks) -> initiator samples 0xE5. spi_sdat_oe rises after the 8th rising edge and drops within 4 cycles of cs_n rising.
- Write 0x31<-0x0B (cmd 0x31), then read 0x31 -> 0x0B. Write 0x00<-0x12, then read 0x00 -> still 0xE5.
- sample_valid with X=0x0123, Y=0xFFFE, Z=0x0100 in IDLE, then multibyte read cmd 0xF2 for 6 bytes -> 23 01 FE FF 00 01. DATA_READY=0 after the transaction.
- With INT_ENABLE=0x80, sample_valid -> spi_int=1. Set 0x31 bit5 -> spi_int=0. Read 0x32 -> spi_int=1 (inverted, DATA_READY clear).
- sample_valid with X=0x1111 mid-burst while reading 0x32..0x33 -> old bytes returned. After cs_n rises, read 0x32 -> 0x11.
- cs_n raised after 5 bits of a write data byte to 0x2E -> register unchanged. Reset asserted mid-read -> spi_sdat_oe=0 next cycle, registers at defaults.
